// File: rtl/full_adder.sv
// full_adder: registered ripple-carry adder with carry-out, signed overflow and a valid flag
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             valid
);
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             carry_d, carry_q, ovf_d, ovf_q, valid_q;
  assign c[0] = cin;
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  always_comb begin
    sum_d   = en ? s : sum_q;
    carry_d = en ? c[WIDTH] : carry_q;
    ovf_d   = en ? c[WIDTH] ^ c[WIDTH-1] : ovf_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      valid_q <= en;
    end
  end
  assign sum       = sum_q;
  assign carry_out = carry_q;
  assign overflow  = ovf_q;
  assign valid     = valid_q;
endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: scoreboard bench for 1-bit and 8-bit full_adder instances
module tb_full_adder;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic en1 = 1'b0, a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
  logic s1, co1, ov1, v1;
  logic en8 = 1'b0, c8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, s8;
  logic co8, ov8, v8;
  logic [2:0] q1[$];
  logic [9:0] q8[$];
  int total = 0, bad = 0;
  full_adder #(.WIDTH(1)) u1 (.clk(clk), .rst(rst), .en(en1), .a(a1), .b(b1), .cin(c1),
    .sum(s1), .carry_out(co1), .overflow(ov1), .valid(v1));
  full_adder #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .en(en8), .a(a8), .b(b8), .cin(c8),
    .sum(s8), .carry_out(co8), .overflow(ov8), .valid(v8));
  task automatic check(input string n, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, act, exp);
    end
  endtask
  // expected words are {overflow, carry_out, sum}
  always @(negedge clk) begin
    if (v1) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL w1_unexpected_valid got=%h want=none", {ov1, co1, s1});
      end else check("w1_result", 16'({ov1, co1, s1}), 16'(q1.pop_front()));
    end
    if (v8) begin
      if (q8.size() == 0) begin
        total++; bad++;
        $display("FAIL w8_unexpected_valid got=%h want=none", {ov8, co8, s8});
      end else check("w8_result", 16'({ov8, co8, s8}), 16'(q8.pop_front()));
    end
  end
  task automatic d1(input logic e, input logic a, input logic b, input logic c, input logic [2:0] x);
    @(posedge clk); #2;
    en1 = e; a1 = a; b1 = b; c1 = c;
    if (e) q1.push_back(x);
  endtask
  task automatic d8(input logic e, input logic [7:0] a, input logic [7:0] b, input logic c,
                    input logic [9:0] x);
    @(posedge clk); #2;
    en8 = e; a8 = a; b8 = b; c8 = c;
    if (e) q8.push_back(x);
  endtask
  logic [2:0] t1 [8] = '{3'b000, 3'b101, 3'b001, 3'b010, 3'b001, 3'b010, 3'b110, 3'b011};
  initial begin
    #3;
    check("reset_w1", 16'({ov1, co1, s1, v1}), 16'h0);
    check("reset_w8", 16'({ov8, co8, s8, v8}), 16'h0);
    @(posedge clk); #2 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = i[2:0];
      d1(1'b1, v[2], v[1], v[0], t1[i]);
    end
    d1(1'b1, 1'b1, 1'b1, 1'b0, 3'b110);
    d1(1'b1, 1'b1, 1'b1, 1'b1, 3'b011);
    d1(1'b1, 1'b1, 1'b0, 1'b0, 3'b001);
    d1(1'b0, 1'b1, 1'b1, 1'b1, 3'b000);
    @(posedge clk); @(negedge clk); #1;
    check("hold_sum_carry_valid", 16'({co1, s1, v1}), 16'b010);
    d1(1'b1, 1'b1, 1'b1, 1'b1, 3'b011);
    d1(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    @(negedge clk); #1;
    check("pre_reset_held", 16'({co1, s1}), 16'b11);
    rst = 1'b1;
    #1;
    check("async_reset_w1", 16'({ov1, co1, s1, v1}), 16'h0);
    check("async_reset_w8", 16'({ov8, co8, s8, v8}), 16'h0);
    #1 rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("no_valid_after_reset", 16'(v1), 16'h0);
    end
    d8(1'b1, 8'hFF, 8'h00, 1'b1, {2'b01, 8'h00});
    d8(1'b1, 8'h7F, 8'h01, 1'b0, {2'b10, 8'h80});
    d8(1'b1, 8'hFF, 8'hFF, 1'b1, {2'b01, 8'hFF});
    d8(1'b1, 8'h00, 8'h00, 1'b0, {2'b00, 8'h00});
    d8(1'b1, 8'h55, 8'h2A, 1'b1, {2'b10, 8'h80});
    d8(1'b1, 8'h80, 8'h80, 1'b0, {2'b11, 8'h00});
    d8(1'b0, 8'h12, 8'h34, 1'b1, 10'h0);
    d8(1'b1, 8'h12, 8'h34, 1'b1, {2'b00, 8'h47});
    for (int i = 0; i < 300; i++) begin
      logic [7:0] ra, rb;
      logic rc, re, ro;
      logic [8:0] t;
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom); re = 1'($urandom);
      t = {1'b0, ra} + {1'b0, rb} + {8'h0, rc};
      ro = (ra[7] == rb[7]) && (t[7] != ra[7]);
      d8(re, ra, rb, rc, {ro, t});
    end
    d8(1'b0, 8'h00, 8'h00, 1'b0, 10'h0);
    repeat (3) @(negedge clk);
    #1;
    check("w1_queue_drained", 16'(q1.size()), 16'h0);
    check("w8_queue_drained", 16'(q8.size()), 16'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
